// File: rtl/multicycle_control_unit.sv
// Multicycle sequencing FSM for an RV64I subset (R/I ALU, ld, sd, beq, bne).
// Drives datapath strobes one phase per cycle and traps on illegal opcodes or memory timeouts.
module multicycle_control_unit #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [6:0]       opcode,
  input  logic [2:0]       funct3,
  input  logic             alu_zero,
  input  logic             imem_ready,
  input  logic             dmem_ready,
  output logic             imem_req,
  output logic             ir_write,
  output logic             dmem_req,
  output logic             dmem_we,
  output logic             alu_src,
  output logic [1:0]       alu_op,
  output logic             mem_to_reg,
  output logic             reg_write,
  output logic             pc_write,
  output logic             pc_src,
  output logic             illegal,
  output logic             bus_error,
  output logic [CNT_W-1:0] retired
);

  localparam int WAIT_W = $clog2(TIMEOUT + 1);

  localparam logic [6:0] OPC_R  = 7'b0110011;
  localparam logic [6:0] OPC_I  = 7'b0010011;
  localparam logic [6:0] OPC_LD = 7'b0000011;
  localparam logic [6:0] OPC_SD = 7'b0100011;
  localparam logic [6:0] OPC_BR = 7'b1100011;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_FN  = 2'b10;

  typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_TRAP} state_t;
  typedef enum logic [2:0] {C_NONE, C_R, C_I, C_LD, C_SD, C_BEQ, C_BNE} class_t;

  state_t             r_state;
  state_t             w_next_state;
  class_t             r_class;
  class_t             w_decode_class;
  logic               w_decode_legal;
  logic [WAIT_W-1:0]  r_wait;
  logic               w_wait_hit;
  logic               w_waiting;
  logic               w_load_class;
  logic               w_retire;
  logic               w_set_illegal;
  logic               w_set_bus_error;
  logic               r_illegal;
  logic               r_bus_error;
  logic [CNT_W-1:0]   r_retired;

  // The last unready cycle before the count would reach TIMEOUT is the one that traps.
  assign w_wait_hit = (r_wait == WAIT_W'(TIMEOUT - 1));
  assign w_waiting  = (r_state == S_FETCH) || (r_state == S_MEM);

  // Branches are split into BEQ/BNE classes so EXEC never needs funct3 again.
  always_comb begin
    w_decode_class = C_NONE;
    w_decode_legal = 1'b1;
    case (opcode)
      OPC_R:  w_decode_class = C_R;
      OPC_I:  w_decode_class = C_I;
      OPC_LD: w_decode_class = C_LD;
      OPC_SD: w_decode_class = C_SD;
      OPC_BR: begin
        if (funct3 == 3'b000)      w_decode_class = C_BEQ;
        else if (funct3 == 3'b001) w_decode_class = C_BNE;
        else                       w_decode_legal = 1'b0;
      end
      default: w_decode_legal = 1'b0;
    endcase
  end

  // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
  always_comb begin
    w_next_state    = r_state;
    w_load_class    = 1'b0;
    w_retire        = 1'b0;
    w_set_illegal   = 1'b0;
    w_set_bus_error = 1'b0;
    imem_req        = 1'b0;
    ir_write        = 1'b0;
    dmem_req        = 1'b0;
    dmem_we         = 1'b0;
    alu_src         = 1'b0;
    alu_op          = ALU_ADD;
    mem_to_reg      = 1'b0;
    reg_write       = 1'b0;
    pc_write        = 1'b0;
    pc_src          = 1'b0;

    case (r_state)
      S_FETCH: begin
        imem_req = 1'b1;
        if (imem_ready) begin
          ir_write     = 1'b1;
          w_next_state = S_DECODE;
        end else if (w_wait_hit) begin
          w_set_bus_error = 1'b1;
          w_next_state    = S_TRAP;
        end
      end
      S_DECODE: begin
        w_load_class = 1'b1;
        if (w_decode_legal) begin
          w_next_state = S_EXEC;
        end else begin
          w_set_illegal = 1'b1;
          w_next_state  = S_TRAP;
        end
      end
      S_EXEC: begin
        case (r_class)
          C_R: begin
            alu_op       = ALU_FN;
            w_next_state = S_WB;
          end
          C_I: begin
            alu_op       = ALU_FN;
            alu_src      = 1'b1;
            w_next_state = S_WB;
          end
          C_LD, C_SD: begin
            alu_src      = 1'b1;
            w_next_state = S_MEM;
          end
          C_BEQ, C_BNE: begin
            alu_op       = ALU_SUB;
            pc_write     = 1'b1;
            pc_src       = (r_class == C_BEQ) ? alu_zero : !alu_zero;
            w_retire     = 1'b1;
            w_next_state = S_FETCH;
          end
          default: w_next_state = S_TRAP;
        endcase
      end
      S_MEM: begin
        dmem_req = 1'b1;
        alu_src  = 1'b1;
        dmem_we  = (r_class == C_SD);
        if (dmem_ready) begin
          if (r_class == C_LD) begin
            w_next_state = S_WB;
          end else begin
            pc_write     = 1'b1;
            w_retire     = 1'b1;
            w_next_state = S_FETCH;
          end
        end else if (w_wait_hit) begin
          w_set_bus_error = 1'b1;
          w_next_state    = S_TRAP;
        end
      end
      S_WB: begin
        reg_write    = 1'b1;
        mem_to_reg   = (r_class == C_LD);
        pc_write     = 1'b1;
        w_retire     = 1'b1;
        w_next_state = S_FETCH;
      end
      default: ;
    endcase

    // A reset cycle aborts the instruction in flight: no strobe may reach the datapath.
    if (reset) begin
      imem_req   = 1'b0;
      ir_write   = 1'b0;
      dmem_req   = 1'b0;
      dmem_we    = 1'b0;
      alu_src    = 1'b0;
      alu_op     = ALU_ADD;
      mem_to_reg = 1'b0;
      reg_write  = 1'b0;
      pc_write   = 1'b0;
      pc_src     = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_FETCH;
      r_class     <= C_NONE;
      r_wait      <= '0;
      r_retired   <= '0;
      r_illegal   <= 1'b0;
      r_bus_error <= 1'b0;
    end else begin
      r_state <= w_next_state;
      if (w_load_class) r_class <= w_decode_class;
      if (w_next_state != r_state) r_wait <= '0;
      else if (w_waiting)          r_wait <= r_wait + WAIT_W'(1);
      if (w_retire)        r_retired   <= r_retired + CNT_W'(1);
      if (w_set_illegal)   r_illegal   <= 1'b1;
      if (w_set_bus_error) r_bus_error <= 1'b1;
    end
  end

  assign illegal   = r_illegal;
  assign bus_error = r_bus_error;
  assign retired   = r_retired;

endmodule
